fir_result_requant: RTL

- Output stage directly downstream of student_fir; consumes each y_out result qualified by valid_strobe_out.
- Rescales the 32-bit signed accumulator with a runtime right shift, rounds, and saturates to a 16-bit signed sample.
- Buffers results in a small FIFO and presents them to a sink (DAC/I2S/bus reader) over a valid/ready handshake.
- Reports saturation and overflow drops via counters.

---
 rtl/fir_result_requant.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fir_result_requant.sv
// fir_result_requant: rounds, right-shifts and saturates FIR accumulator results,
// then queues them in a first-word fall-through FIFO drained over valid/ready.
module fir_result_requant #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_strobe_in,
  input  logic [IN_WIDTH-1:0]      y_in,
  input  logic [4:0]               shift_i,
  output logic [OUT_WIDTH-1:0]     sample_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   fill_level_o,
  output logic                     drop_o,
  output logic [CNT_WIDTH-1:0]     sat_count_o,
  output logic [CNT_WIDTH-1:0]     drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IN_WIDTH + 1;

  localparam logic signed [EW-1:0] SAT_HI = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_LO = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  localparam logic [OUT_WIDTH-1:0] CLAMP_HI = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] CLAMP_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // stage 1: one extra bit of headroom so the rounding add cannot overflow
  logic signed [EW-1:0] y_ext;
  logic signed [EW-1:0] rnd_add;
  logic signed [EW-1:0] rnd_sum;
  logic signed [EW-1:0] s1_next;
  logic signed [EW-1:0] s1_q;
  logic                 v1_q;

  always_comb begin
    y_ext   = {y_in[IN_WIDTH-1], y_in};
    rnd_add = '0;
    if (shift_i != 5'd0) begin
      rnd_add = EW'(1) << (shift_i - 5'd1);
    end
    rnd_sum = y_ext + rnd_add;
    s1_next = rnd_sum >>> shift_i;
  end

  // stage 2: clamp to the output range
  logic [OUT_WIDTH-1:0] s2_next;
  logic                 s2_sat_next;
  logic [OUT_WIDTH-1:0] s2_q;
  logic                 s2_sat_q;
  logic                 v2_q;

  always_comb begin
    s2_next     = s1_q[OUT_WIDTH-1:0];
    s2_sat_next = 1'b0;
    if (s1_q > SAT_HI) begin
      s2_next     = CLAMP_HI;
      s2_sat_next = 1'b1;
    end else if (s1_q < SAT_LO) begin
      s2_next     = CLAMP_LO;
      s2_sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s2_sat_q <= 1'b0;
    end else begin
      v1_q <= valid_strobe_in;
      v2_q <= v1_q;
      if (valid_strobe_in) begin
        s1_q <= s1_next;
      end
      if (v1_q) begin
        s2_q     <= s2_next;
        s2_sat_q <= s2_sat_next;
      end
    end
  end

  // FIFO: pointers are AW bits wide, so they wrap modulo DEPTH on their own
  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;
  logic [OUT_WIDTH-1:0] last_q;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign pop   = !empty && ready_in;
  assign push  = v2_q && (!full || pop);
  assign drop  = v2_q && !push;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // status counters stick at all-ones instead of wrapping
  logic [CNT_WIDTH-1:0] sat_count_q;
  logic [CNT_WIDTH-1:0] drop_count_q;
  logic                 drop_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_count_q  <= '0;
      drop_count_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      drop_q <= drop;
      if (drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
      if (v2_q && s2_sat_q && (sat_count_q != '1)) begin
        sat_count_q <= sat_count_q + 1'b1;
      end
    end
  end

  assign valid_out    = !empty;
  assign sample_out   = empty ? last_q : mem_q[rd_ptr_q];
  assign fill_level_o = count_q;
  assign drop_o       = drop_q;
  assign sat_count_o  = sat_count_q;
  assign drop_count_o = drop_count_q;

endmodule
